// File: rtl/irrigation_controller_pkg.sv
// Shared definitions for the irrigation decision stage: state encoding,
// default tuning values and the tank-level width.
package irrigation_controller_pkg;

  localparam int LEVEL_W = 3;

  localparam int DEF_DEBOUNCE_TICKS = 4;
  localparam int DEF_MIN_DWELL      = 8;
  localparam int DEF_LEVEL_LOW      = 2;
  localparam int DEF_LEVEL_HIGH     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIP  = 2'd1,
    SPRAY = 2'd2,
    FAULT = 2'd3
  } irr_state_t;

endpackage

// File: rtl/irrigation_controller_sensor_debounce.sv
// Two-flop synchronizer followed by a tick-paced debounce counter for one
// asynchronous field sensor. The filtered value only follows the raw input
// after it has held a new value for DEBOUNCE_TICKS consecutive ticks.
module sensor_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic raw,
  output logic filtered
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // Synchronizer runs every clock, independent of tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync <= 2'b00;
    else     sync <= {sync[0], raw};
  end

  // Count ticks of disagreement; the last counted tick commits the new value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= 4'd0;
      filtered <= 1'b0;
    end else if (tick) begin
      if (sync[1] != filtered) begin
        if (cnt == 4'(DEBOUNCE_TICKS - 1)) begin
          filtered <= sync[1];
          cnt      <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/irrigation_controller.sv
// Irrigation decision stage: conditions the three field sensors, picks
// drip/spray mode with a minimum dwell, raises the tank-dry alarm, runs the
// fill-valve hysteresis and flags tank-level discontinuities.
//
// state | meaning
// IDLE  | no irrigation, waiting for soil demand and a non-empty tank
// DRIP  | drip line active
// SPRAY | sprinkler active
// FAULT | tank ran dry while irrigating, waiting for refill to LEVEL_HIGH
module irrigation_controller
  import irrigation_controller_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int MIN_DWELL      = DEF_MIN_DWELL,
  parameter int LEVEL_LOW      = DEF_LEVEL_LOW,
  parameter int LEVEL_HIGH     = DEF_LEVEL_HIGH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic               solo,
  input  logic               umidade,
  input  logic               temperatura,
  input  logic [LEVEL_W-1:0] level,
  output logic               gotejamento,
  output logic               aspersao,
  output logic               valvula,
  output logic               alarme,
  output logic               erro
);

  localparam logic [7:0]         DWELL_MAX = 8'(MIN_DWELL);
  localparam logic [LEVEL_W-1:0] LVL_LO    = LEVEL_W'(LEVEL_LOW);
  localparam logic [LEVEL_W-1:0] LVL_HI    = LEVEL_W'(LEVEL_HIGH);

  logic f_solo, f_umidade, f_temperatura;

  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_solo (
    .clk(clk), .clr(clr), .tick(tick), .raw(solo), .filtered(f_solo));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_umidade (
    .clk(clk), .clr(clr), .tick(tick), .raw(umidade), .filtered(f_umidade));
  sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_temperatura (
    .clk(clk), .clr(clr), .tick(tick), .raw(temperatura), .filtered(f_temperatura));

  logic       wants_spray, wants_drip;
  irr_state_t demand;
  irr_state_t state, state_nxt;
  logic [7:0] dwell, dwell_nxt;

  assign wants_spray = f_solo & f_temperatura & ~f_umidade;
  assign wants_drip  = f_solo & ~wants_spray;
  assign demand      = wants_spray ? SPRAY : (wants_drip ? DRIP : IDLE);

  // State and dwell registers advance only on tick.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      dwell <= 8'd0;
    end else if (tick) begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  // Next-state: empty tank beats dwell; dwell saturates at its minimum.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    case (state)
      IDLE: begin
        if (level != '0 && demand != IDLE) begin
          state_nxt = demand;
          dwell_nxt = 8'd0;
        end
      end
      DRIP, SPRAY: begin
        if (level == '0) begin
          state_nxt = FAULT;
          dwell_nxt = 8'd0;
        end else if (dwell < DWELL_MAX) begin
          dwell_nxt = dwell + 8'd1;
        end else if (demand != state) begin
          state_nxt = demand;
          dwell_nxt = 8'd0;
        end
      end
      FAULT: begin
        if (level >= LVL_HI) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode outputs decode straight from the state flop so clr drops them at once.
  always_comb begin
    gotejamento = (state == DRIP);
    aspersao    = (state == SPRAY);
    alarme      = (state == FAULT);
  end

  // Fill valve hysteresis, independent of the irrigation mode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                         valvula <= 1'b0;
    else if (tick && level <= LVL_LO) valvula <= 1'b1;
    else if (tick && level >= LVL_HI) valvula <= 1'b0;
  end

  logic [LEVEL_W-1:0] level_prev;
  logic [LEVEL_W-1:0] level_diff;
  logic               armed;

  assign level_diff = (level > level_prev) ? (level - level_prev) : (level_prev - level);

  // Level continuity check; the first tick after reset only captures level_prev.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      level_prev <= '0;
      armed      <= 1'b0;
      erro       <= 1'b0;
    end else if (tick) begin
      level_prev <= level;
      armed      <= 1'b1;
      if (armed && level_diff > LEVEL_W'(1)) erro <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irrigation_controller.sv
// Self-checking bench for irrigation_controller: directed scenarios plus a
// randomized phase, every cycle compared against a behavioural model.
module tb_irrigation_controller;

  localparam int DB = 4;
  localparam int DW = 8;
  localparam int LO = 2;
  localparam int HI = 6;

  // Behavioural mode names, independent of the design's encoding.
  localparam int M_OFF   = 100;
  localparam int M_DRIP  = 101;
  localparam int M_SPRAY = 102;
  localparam int M_DRY   = 103;

  logic       clk = 1'b0;
  logic       clr, tick, solo, umidade, temperatura;
  logic [2:0] level;
  logic       gotejamento, aspersao, valvula, alarme, erro;

  int checks   = 0;
  int failures = 0;

  irrigation_controller #(
    .DEBOUNCE_TICKS(DB), .MIN_DWELL(DW), .LEVEL_LOW(LO), .LEVEL_HIGH(HI)
  ) dut (
    .clk(clk), .clr(clr), .tick(tick), .solo(solo), .umidade(umidade),
    .temperatura(temperatura), .level(level), .gotejamento(gotejamento),
    .aspersao(aspersao), .valvula(valvula), .alarme(alarme), .erro(erro)
  );

  always #5 clk = ~clk;

  // Reference model state (index 0 = soil, 1 = humidity, 2 = temperature)
  bit m_s1[3], m_s2[3], m_filt[3];
  int m_run[3];
  int m_mode, m_dwell, m_prev;
  bit m_valve, m_err, m_armed;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_run[i] = 0;
    end
    m_mode = M_OFF; m_dwell = 0; m_prev = 0;
    m_valve = 0; m_err = 0; m_armed = 0;
  endtask

  task automatic model_edge(input bit tk, input bit r0, input bit r1, input bit r2, input int lvl);
    int want;
    bit watering;
    if (tk) begin
      if (!m_filt[0])                 want = M_OFF;
      else if (m_filt[2] && !m_filt[1]) want = M_SPRAY;
      else                            want = M_DRIP;
      watering = (m_mode == M_DRIP) || (m_mode == M_SPRAY);
      if (watering && lvl == 0) begin
        m_mode = M_DRY; m_dwell = 0;
      end else if (m_mode == M_OFF) begin
        if (lvl > 0 && want != M_OFF) begin m_mode = want; m_dwell = 0; end
      end else if (watering) begin
        if (m_dwell < DW) m_dwell++;
        else if (want != m_mode) begin m_mode = want; m_dwell = 0; end
      end else if (lvl >= HI) begin
        m_mode = M_OFF;
      end
      if (lvl <= LO) m_valve = 1;
      else if (lvl >= HI) m_valve = 0;
      if (m_armed && (lvl - m_prev > 1 || m_prev - lvl > 1)) m_err = 1;
      m_prev = lvl; m_armed = 1;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_filt[i] = m_s2[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1]; m_s2[2] = m_s1[2];
    m_s1[0] = r0; m_s1[1] = r1; m_s1[2] = r2;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".gotejamento"}, gotejamento, m_mode == M_DRIP);
    check_eq({tag, ".aspersao"},    aspersao,    m_mode == M_SPRAY);
    check_eq({tag, ".alarme"},      alarme,      m_mode == M_DRY);
    check_eq({tag, ".valvula"},     valvula,     m_valve);
    check_eq({tag, ".erro"},        erro,        m_err);
    check_eq({tag, ".exclusive"},   gotejamento & aspersao, 0);
  endtask

  // One clock with the current inputs; called and returns at a falling edge.
  task automatic step(input bit tk, input string tag);
    tick = tk;
    @(posedge clk);
    model_edge(tk, solo, umidade, temperatura, int'(level));
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic run(input int n, input int period, input string tag);
    for (int i = 0; i < n; i++) step((i % period) == period - 1, tag);
  endtask

  // Asynchronous clear between edges; outputs must drop before any clock.
  task automatic pulse_clr(input string tag);
    tick = 1'b0;
    #1 clr = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 clr = 1'b0;
    @(negedge clk);
    model_edge(1'b0, solo, umidade, temperatura, int'(level));
  endtask

  initial begin
    clr = 1'b1; tick = 1'b0; solo = 1'b0; umidade = 1'b0; temperatura = 1'b0; level = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    clr = 1'b0;

    // Drip demand from a clean reset
    solo = 1'b1; umidade = 1'b1; temperatura = 1'b0; level = 3'd5;
    run(40, 4, "drip_entry");
    check_eq("drip_established", gotejamento, 1);
    check_eq("drip_no_spray", aspersao, 0);

    // Switch demand to spray; dwell holds DRIP for a while
    umidade = 1'b0; temperatura = 1'b1;
    run(16, 4, "spray_wait");
    check_eq("dwell_holds_drip", gotejamento, 1);
    run(64, 4, "spray_switch");
    check_eq("spray_established", aspersao, 1);

    // Tank drains while spraying, then refills
    for (int lv = 4; lv >= 0; lv--) begin
      level = 3'(lv);
      run(4, 4, "drain");
    end
    check_eq("dry_alarm", alarme, 1);
    check_eq("dry_valve", valvula, 1);
    for (int lv = 1; lv <= 6; lv++) begin
      level = 3'(lv);
      step(1'b1, "refill");
      if (lv == 6) begin
        check_eq("refill_alarm_off", alarme, 0);
        check_eq("refill_valve_off", valvula, 0);
      end
      run(3, 4, "refill");
    end
    check_eq("refill_no_erro", erro, 0);

    // Soil glitch shorter than the debounce window
    solo = 1'b0; umidade = 1'b0; temperatura = 1'b0; level = 3'd4;
    pulse_clr("glitch_clr");
    solo = 1'b1;
    run(12, 4, "glitch_hi");
    solo = 1'b0;
    run(40, 4, "glitch_lo");
    check_eq("glitch_goto", gotejamento, 0);
    check_eq("glitch_asp", aspersao, 0);

    // Level discontinuity 3 -> 5
    level = 3'd3;
    run(8, 4, "jump_pre");
    level = 3'd5;
    run(4, 4, "jump");
    check_eq("erro_set", erro, 1);
    level = 3'd4;
    run(16, 4, "jump_hold");
    check_eq("erro_sticky", erro, 1);
    pulse_clr("erro_clr");
    check_eq("erro_cleared", erro, 0);

    // Clear in the middle of drip, then a big level step on the first tick
    solo = 1'b1; umidade = 1'b1; level = 3'd4;
    run(40, 4, "pre_clr_drip");
    check_eq("pre_clr_drip", gotejamento, 1);
    step(1'b0, "pre_clr_notick");
    pulse_clr("mid_drip_clr");
    check_eq("clr_drops_drip", gotejamento, 0);
    level = 3'd7;
    run(8, 4, "post_clr");
    check_eq("first_tick_disarmed", erro, 0);

    // Randomized phase
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(39) == 0) solo = ~solo;
      if ($urandom_range(39) == 0) umidade = ~umidade;
      if ($urandom_range(39) == 0) temperatura = ~temperatura;
      if ($urandom_range(59) == 0) level = 3'($urandom_range(7));
      else if ($urandom_range(5) == 0) begin
        if ($urandom_range(1) == 0 && level != 3'd0) level = level - 3'd1;
        else if (level != 3'd7) level = level + 3'd1;
      end
      if ($urandom_range(799) == 0) pulse_clr("rand_clr");
      step($urandom_range(3) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
